// File: rtl/psram_arb_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : psram_arb_mc
// Brief    : NUM_CH-channel read/write burst arbiter in front of the PSRAM
//            controller, fixed-priority or round-robin selection.
// Revision : 1.0
// ============================================================================
module psram_arb_mc #(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 64,
    parameter int BURST_BEATS = 4,
    parameter int CMD_GAP     = 2,
    parameter int ARB_MODE    = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_psram_init_calib,
    output logic                         o_psram_cmd_en,
    output logic                         o_psram_cmd,
    output logic [ADDR_W-1:0]            o_psram_addr,
    output logic [DATA_W-1:0]            o_psram_wr_data,
    output logic [DATA_W/8-1:0]          o_psram_data_mask,
    input  logic [DATA_W-1:0]            i_psram_rd_data,
    input  logic                         i_psram_rd_data_valid,
    input  logic [NUM_CH-1:0]            i_ch_req,
    input  logic [NUM_CH-1:0]            i_ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]     i_ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]     i_ch_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0]   i_ch_mask,
    output logic [NUM_CH-1:0]            o_ch_gnt,
    output logic [NUM_CH-1:0]            o_ch_rvalid,
    output logic [DATA_W-1:0]            o_rd_data,
    output logic                         o_busy
);

    localparam int         IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         MASK_W      = DATA_W / 8;
    localparam logic [4:0] c_last_beat = 5'(BURST_BEATS - 1);
    localparam logic [3:0] c_gap_last  = 4'(CMD_GAP);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    win_idx;
    logic                win_vld;
    logic                grant;
    logic [4:0]          beat_q;
    logic [3:0]          gap_q;

    logic                cmd_en_q;
    logic                cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [MASK_W-1:0]   mask_q;
    logic [NUM_CH-1:0]   gnt_q;
    logic [NUM_CH-1:0]   rvalid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                busy_q;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return IDX_W'(s);
    endfunction

    // Descending scan so the last hit is the lowest index (or nearest to ptr).
    always_comb begin
        win_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ARB_MODE == 0) begin
                if (i_ch_req[k]) win_idx = IDX_W'(k);
            end else if (i_ch_req[rr_idx(ptr_q, k)]) begin
                win_idx = rr_idx(ptr_q, k);
            end
        end
    end

    assign win_vld = |i_ch_req;
    assign grant   = (state_q == S_IDLE) && i_psram_init_calib && win_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
                if (i_psram_init_calib) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!i_psram_init_calib) begin
                    state_d = S_INIT;
                end else if (win_vld) begin
                    if (!i_ch_we[win_idx])     state_d = S_READ;
                    else if (BURST_BEATS == 1) state_d = S_GAP;
                    else                       state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (beat_q == c_last_beat) state_d = S_GAP;
            end
            S_READ: begin
                if (i_psram_rd_data_valid && (beat_q == c_last_beat)) state_d = S_GAP;
            end
            S_GAP: begin
                // A calibration loss is only acted on once the burst has drained.
                if (gap_q == c_gap_last) state_d = i_psram_init_calib ? S_IDLE : S_INIT;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_INIT;
            ptr_q     <= '0;
            owner_q   <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            cmd_en_q  <= 1'b0;
            cmd_q     <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            mask_q    <= '0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != S_IDLE);
            cmd_en_q  <= 1'b0;
            cmd_q     <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            mask_q    <= '0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            gap_q     <= (state_q == S_GAP) ? gap_q + 4'd1 : 4'd0;

            if (grant) begin
                gnt_q[win_idx] <= 1'b1;
                cmd_en_q       <= 1'b1;
                cmd_q          <= i_ch_we[win_idx];
                addr_q         <= i_ch_addr[win_idx*ADDR_W +: ADDR_W];
                wr_data_q      <= i_ch_wdata[win_idx*DATA_W +: DATA_W];
                mask_q         <= i_ch_mask[win_idx*MASK_W +: MASK_W];
                owner_q        <= win_idx;
                // Beat 0 of a write leaves with the command; reads count from zero.
                beat_q         <= i_ch_we[win_idx] ? 5'd1 : 5'd0;
                if (ARB_MODE != 0) begin
                    ptr_q <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
                end
            end

            if (state_q == S_WRITE) begin
                wr_data_q <= i_ch_wdata[owner_q*DATA_W +: DATA_W];
                mask_q    <= i_ch_mask[owner_q*MASK_W +: MASK_W];
                beat_q    <= beat_q + 5'd1;
            end

            if ((state_q == S_READ) && i_psram_rd_data_valid) begin
                rd_data_q         <= i_psram_rd_data;
                rvalid_q[owner_q] <= 1'b1;
                beat_q            <= beat_q + 5'd1;
            end
        end
    end

    assign o_psram_cmd_en    = cmd_en_q;
    assign o_psram_cmd       = cmd_q;
    assign o_psram_addr      = addr_q;
    assign o_psram_wr_data   = wr_data_q;
    assign o_psram_data_mask = mask_q;
    assign o_ch_gnt          = gnt_q;
    assign o_ch_rvalid       = rvalid_q;
    assign o_rd_data         = rd_data_q;
    assign o_busy            = busy_q;

endmodule
`default_nettype wire

// File: doc/psram_arb_mc.md
Name: psram_arb_mc

Overview:
N-channel arbiter in front of the Gowin PSRAM memory interface. It generalises the two-port read/write arbiter to NUM_CH symmetric channels, each able to issue read or write bursts. Fixed-priority and round-robin modes are selectable, with burst length and command-recovery gap as parameters. It sits between the frame-buffer clients (SPI write path, HDMI scan-out, future DMA) and the PSRAM controller.

Parameters:
NUM_CH, 3, number of client channels (2..8)
ADDR_W, 21, PSRAM address width
DATA_W, 64, PSRAM data beat width
BURST_BEATS, 4, data beats per command (1..16)
CMD_GAP, 2, idle cycles enforced after a burst completes before the next cmd_en (0..15)
ARB_MODE, 1, 0 = fixed priority (ch0 highest), 1 = round-robin

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_psram_init_calib  in  1  controller calibration done
o_psram_cmd_en  out  1  command strobe
o_psram_cmd  out  1  1 = write, 0 = read
o_psram_addr  out  ADDR_W  burst address
o_psram_wr_data  out  DATA_W  write beat
o_psram_data_mask  out  DATA_W/8  byte mask (1 = masked)
i_psram_rd_data  in  DATA_W  read beat
i_psram_rd_data_valid  in  1  read beat valid
i_ch_req  in  NUM_CH  per-channel request
i_ch_we  in  NUM_CH  per-channel 1 = write
i_ch_addr  in  NUM_CH*ADDR_W  flattened addresses, ch k at [k*ADDR_W +: ADDR_W]
i_ch_wdata  in  NUM_CH*DATA_W  flattened write data
i_ch_mask  in  NUM_CH*DATA_W/8  flattened byte masks
o_ch_gnt  out  NUM_CH  one-hot grant pulse
o_ch_rvalid  out  NUM_CH  one-hot read beat valid for the owning channel
o_rd_data  out  DATA_W  read beat, broadcast to all channels
o_busy  out  1  high in every state except S_IDLE

Behaviour:
- Reset: all outputs 0; FSM = S_INIT; round-robin pointer = 0.
- S_INIT: wait for i_psram_init_calib = 1, then go to S_IDLE. No grants are issued before calibration.
- S_IDLE: if any i_ch_req is set, the arbiter selects a winner combinationally. Registered the same cycle: o_ch_gnt[w] = 1, o_psram_cmd_en = 1, o_psram_cmd = i_ch_we[w], o_psram_addr = addr[w], beat 0 of data/mask. All of these are 1-cycle pulses and appear on the clock edge after selection.
- Winner selection, ARB_MODE 0: lowest requesting index wins.
- Winner selection, ARB_MODE 1: first requester at or above the pointer wins, searching with wrap-around. On each grant, pointer = w+1 mod NUM_CH. With all channels requesting, grants cycle 0,1,2,0,...
- A channel holds req/we/addr/wdata/mask stable until it sees gnt. It may drop req in the cycle after gnt.
- S_WRITE: beat k (1..BURST_BEATS-1) is taken from i_ch_wdata/i_ch_mask of the owner in cycle gnt+k. The channel advances its data every cycle after gnt. o_psram_wr_data/mask are registered, so beat k appears at cycle gnt+k+1. After the last beat, go to S_GAP. With BURST_BEATS = 1, go directly to S_GAP.
- S_READ: each i_psram_rd_data_valid pulse produces o_rd_data = i_psram_rd_data and o_ch_rvalid[owner] = 1 one cycle later. A beat counter counts to BURST_BEATS, then the FSM goes to S_GAP. o_ch_rvalid is never asserted for a non-owner.
- S_GAP: wait CMD_GAP cycles, then go to S_IDLE. With CMD_GAP = 0, go to S_IDLE on the next edge. Minimum gnt-to-gnt spacing is BURST_BEATS+CMD_GAP+1 cycles for writes.
- Requests arriving while busy are held pending. They are not lost, since req is level-sensitive.
- i_psram_rd_data_valid outside S_READ is ignored. No rvalid is produced and no counter changes.
- If i_psram_init_calib drops, the current burst completes, then the FSM returns to S_INIT.
- Reset mid-burst: outputs clear immediately and asynchronously. The FSM returns to S_INIT and the pointer returns to 0.

Test Plan:
- RR contention: NUM_CH = 3, ARB_MODE 1, all req = 1 (we = 0,1,0) held for 12 bursts -> grant order 0,1,2,0,1,2,..., each read receives exactly 4 rvalid on its own bit only.
- Fixed priority: ARB_MODE 0, req = 3'b110 held -> ch1 granted every time, ch2 never; drop ch1 req -> ch2 granted on the next S_IDLE.
- Write burst: ch2 writes addr 0x1234 with beats 0xA..0xD, mask 0 -> one cmd_en with cmd = 1, addr = 0x1234; wr_data 0xA,0xB,0xC,0xD on consecutive cycles; next cmd_en no earlier than 4+2+1 = 7 cycles after gnt.
- Calibration gating: init_calib = 0 for 50 cycles with req = 3'b111 -> no gnt and o_busy = 1; calib = 1 -> first gnt within 2 cycles.
- Stray valid: rd_data_valid pulsed in S_IDLE and S_GAP -> no o_ch_rvalid; the next read still counts exactly 4 beats.
- Reset mid-read after 2 beats -> all outputs 0 immediately; after release and calib, the ch0 request is granted first.
